// File: rtl/uart_packet_tx.sv
// 8N1 packet serializer: N_BYTES payload frames, LSB first, followed by an idle gap.
// Define TX_CRC_APPEND_EN to append the CRC-16/MODBUS of the payload, low byte first.
module uart_packet_tx #(
   parameter int N_BYTES  = 16,
   parameter int CLK_DIV  = 434,
   parameter int GAP_BITS = 40
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [8*N_BYTES-1:0]   data_in,
   input  logic                   start,
   output logic                   ready,
   output logic                   done,
   output logic                   TXD
);

`ifdef TX_CRC_APPEND_EN
   localparam int FRAMES = N_BYTES + 2;
`else
   localparam int FRAMES = N_BYTES;
`endif
   localparam int IW = $clog2(N_BYTES + 2);
   localparam int BW = $clog2(GAP_BITS + 1);
   localparam logic [15:0]   DIV_LOAD  = 16'(CLK_DIV - 1);
   localparam logic [15:0]   GAP_LOAD  = 16'(CLK_DIV - 2);
   localparam logic [IW-1:0] LAST_IDX  = IW'(FRAMES - 1);
   localparam logic [BW-1:0] LAST_GAP  = BW'(GAP_BITS - 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(7);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

   state_t                 state_q, state_d;
   logic [15:0]            div_q, div_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [IW-1:0]          byte_q, byte_d, byte_inc;
   logic [7:0]             shift_q, shift_d, next_byte;
   logic [8*N_BYTES-1:0]   payload_q, payload_d;
   logic                   txd_q, txd_d;
   logic                   period_end;

`ifdef TX_CRC_APPEND_EN
   logic [15:0] crc_q, crc_d;
   logic        is_payload;

   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
      logic fb;
      fb = crc[0] ^ b;
      return (crc >> 1) ^ (fb ? 16'hA001 : 16'h0000);
   endfunction

   assign is_payload = int'(byte_q) < N_BYTES;
`endif

   assign period_end = (div_q == '0);
   assign byte_inc   = byte_q + 1'b1;
   assign TXD        = txd_q;

   // Byte loaded at the end of a stop bit; the CRC is already frozen by then.
   always_comb begin
      next_byte = '0;
      for (int k = 0; k < N_BYTES; k++)
         if (byte_inc == IW'(k)) next_byte = payload_q[8*k +: 8];
`ifdef TX_CRC_APPEND_EN
      if (byte_inc == IW'(N_BYTES))     next_byte = crc_q[7:0];
      if (byte_inc == IW'(N_BYTES + 1)) next_byte = crc_q[15:8];
`endif
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path can infer a latch.
      state_d   = state_q;
      div_d     = period_end ? DIV_LOAD : div_q - 1'b1;
      bit_d     = bit_q;
      byte_d    = byte_q;
      shift_d   = shift_q;
      payload_d = payload_q;
      ready     = 1'b0;
      done      = 1'b0;
`ifdef TX_CRC_APPEND_EN
      crc_d     = crc_q;
`endif
      case (state_q)
         S_IDLE: begin
            ready = 1'b1;
            div_d = DIV_LOAD;
            if (start) begin
               state_d   = S_START;
               payload_d = data_in;
               shift_d   = data_in[7:0];
               byte_d    = '0;
`ifdef TX_CRC_APPEND_EN
               crc_d     = 16'hFFFF;
`endif
            end
         end
         S_START: begin
            if (period_end) begin
               state_d = S_DATA;
               bit_d   = '0;
`ifdef TX_CRC_APPEND_EN
               if (is_payload) crc_d = crc_step(crc_q, shift_q[0]);
`endif
            end
         end
         S_DATA: begin
            if (period_end) begin
               if (bit_q == LAST_DATA) begin
                  state_d = S_STOP;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = {1'b0, shift_q[7:1]};
`ifdef TX_CRC_APPEND_EN
                  if (is_payload) crc_d = crc_step(crc_q, shift_q[1]);
`endif
               end
            end
         end
         S_STOP: begin
            if (period_end) begin
               if (byte_q == LAST_IDX) begin
                  done    = 1'b1;
                  state_d = S_GAP;
                  // IDLE accepts on its first cycle, so the gap state runs one cycle short.
                  div_d   = GAP_LOAD;
                  bit_d   = '0;
               end else begin
                  state_d = S_START;
                  byte_d  = byte_inc;
                  shift_d = next_byte;
               end
            end
         end
         S_GAP: begin
            if (period_end) begin
               if (bit_q == LAST_GAP) state_d = S_IDLE;
               else                   bit_d   = bit_q + 1'b1;
            end
         end
         default: state_d = S_GAP;
      endcase

      txd_d = (state_d == S_START) ? 1'b0 :
              (state_d == S_DATA)  ? shift_d[0] : 1'b1;
   end

   // NOTE: registers use <= so every flop samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_GAP;
         div_q   <= DIV_LOAD;
         bit_q   <= '0;
         byte_q  <= '0;
         txd_q   <= 1'b1;
`ifdef TX_CRC_APPEND_EN
         crc_q   <= 16'hFFFF;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         txd_q   <= txd_d;
`ifdef TX_CRC_APPEND_EN
         crc_q   <= crc_d;
`endif
      end
   end

   // NOTE: pure datapath registers carry no reset; they are always loaded before use.
   always_ff @(posedge clk) begin
      payload_q <= payload_d;
      shift_q   <= shift_d;
   end

endmodule

// File: doc/uart_packet_tx.md
Name: uart_packet_tx

Overview:
- Transmit-side counterpart of the UART packet receiver on the DE2-115 link.
- Accepts one N-byte packet as a flat bus and serializes it on TXD as 8N1 frames, LSB first.
- Appends a CRC-16 (two bytes) so the far-end receiver's checksum residue evaluates to zero.
- Enforces an idle gap after every packet; the receiver uses that gap to delimit packets.

Parameters:
N_BYTES, 16, payload bytes per packet.
CLK_DIV, 434, clk cycles per bit period (50 MHz / 115200); legal range 2..65535.
GAP_BITS, 40, idle bit periods after each packet's last stop bit. Minimum 33: the receiver needs ≥32.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
data_in  in  8*N_BYTES  packet payload; byte k = data_in[8k+7:8k]; byte 0 sent first
start  in  1  request to send; accepted only on a cycle with ready=1
ready  out  1  1 = idle and gap satisfied, start will be accepted
done  out  1  one-cycle pulse when the last stop bit of the packet completes
TXD  out  1  serial line, idle high, registered output

Behaviour:
- Reset values: TXD=1, ready=0, done=0, FSM=GAP, bit counter=0, byte index=0, CRC=16'hFFFF.
- Reset mid-frame aborts the frame. TXD returns high at the next edge, and a full gap is enforced before ready rises, so the receiver discards the partial packet.
- States:
  - IDLE (ready=1)
  - START
  - DATA
  - STOP
  - GAP
- IDLE, start=1: latch data_in into the payload register, set byte index=0, CRC=16'hFFFF, go to START. ready falls on the next edge. data_in is don't-care after acceptance.
- START: TXD=0 for CLK_DIV cycles. The first TXD=0 edge is the edge after the accepting cycle (latency 1).
- DATA: 8 bit periods, TXD = shift_reg[0], shift right every CLK_DIV cycles.
  - Payload bytes: at the start of each bit period, CRC is updated with the transmitted bit.
  - Serial reflected update: fb = crc[0]^bit; crc = (crc>>1) ^ (fb ? 16'hA001 : 0). This is CRC-16/MODBUS.
  - CRC bytes: the CRC is not updated.
- STOP: TXD=1 for CLK_DIV cycles. At the end of the period, one of:
  - more bytes remain → START with the next byte loaded;
  - else done=1 for exactly one cycle → GAP.
- Byte order on the wire: payload 0..N_BYTES-1, then CRC[7:0], then CRC[15:8]. The CRC value used is the one frozen after the last payload bit.
- GAP: TXD=1 for GAP_BITS*CLK_DIV cycles → IDLE.
- Bit timing: a single down-counter, CLK_DIV-1..0; the period ends on the cycle the counter equals 0. No fractional divide.
- Packet duration from accepting edge to done: (N_BYTES+2)*10*CLK_DIV cycles. Next ready is GAP_BITS*CLK_DIV cycles after done.
- Byte index width: clog2(N_BYTES+2). No wrap beyond N_BYTES+1.
- start while ready=0 is ignored, not queued. start held high in IDLE sends back-to-back packets, each separated by a full gap.
- rst and start on the same cycle: rst wins.

Optional Feature:
TX_CRC_APPEND_EN.
- Defined: behaviour as above, N_BYTES+2 frames per packet.
- Undefined: no CRC logic is synthesized and exactly N_BYTES frames are sent. done fires after payload byte N_BYTES-1, and the duration becomes N_BYTES*10*CLK_DIV cycles.

Test Plan:
- CRC vector. Macro on, N_BYTES=9, CLK_DIV=4, payload "123456789" (0x31..0x39). Required wire bytes: 31..39, then 37, then 4B, each with start bit 0 and stop bit 1. done pulses at cycle 440 after acceptance.
- Reset recovery. rst during byte 3 of a packet: TXD=1 the next cycle; ready stays 0 for GAP_BITS*CLK_DIV cycles after rst deasserts, then becomes 1. The next packet is byte-exact.
- Busy/held start.
  - start pulsed while ready=0 is ignored: exactly one packet is sent.
  - start held high: two packets, with TXD high for exactly GAP_BITS*CLK_DIV cycles between done and the next start bit.
- Loopback. TXD feeds the existing receiver, CLK_DIV=434, N_BYTES=16, payload 0x00..0x0F. The receiver reports valid data with univ_com_wire byte k = k and the checksum OK.
- Macro off. N_BYTES=4, payload AA 55 00 FF: exactly 4 frames, no CRC bytes; done occurs at cycle 160 with CLK_DIV=4.
